// File: rtl/n64_bit_rx.sv
// N64 Joybus receiver: measures low/high pulse widths on the synchronized line,
// decodes bits into bytes MSB first and ends the frame on idle-high timeout.
module n64_bit_rx #(
    parameter int unsigned US_CYCLES  = 12,
    parameter int unsigned ONE_MAX_US = 2,
    parameter int unsigned LOW_MAX_US = 5,
    parameter int unsigned IDLE_US    = 5
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned ONE_MAX  = ONE_MAX_US * US_CYCLES;
    localparam int unsigned LOW_MAX  = LOW_MAX_US * US_CYCLES;
    localparam int unsigned IDLE_MAX = IDLE_US * US_CYCLES;
    localparam int unsigned CNT_TOP  = (LOW_MAX > IDLE_MAX) ? LOW_MAX : IDLE_MAX;
    localparam int unsigned CW       = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] ONE_MAX_C  = CW'(ONE_MAX);
    localparam logic [CW-1:0] LOW_MAX_C  = CW'(LOW_MAX);
    localparam logic [CW-1:0] IDLE_MAX_C = CW'(IDLE_MAX);
    localparam logic [CW-1:0] CNT_SAT    = '1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;

    logic          s1_q, s2_q, s3_q;
    logic          fall, rise;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          pend_bit_q, pend_bit_d;
    logic          pend_valid_q, pend_valid_d;
    logic          err_q, err_d;
    logic [7:0]    rx_data_d;
    logic          rx_valid_d, frame_done_d, frame_err_d, busy_d;

    assign fall = s3_q & ~s2_q;
    assign rise = ~s3_q & s2_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        pend_bit_d   = pend_bit_q;
        pend_valid_d = pend_valid_q;
        err_d        = err_q;
        rx_data_d    = rx_data;
        rx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy;
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StLow;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end
            end
            StLow: begin
                if (rise) begin
                    // A pulse that already timed out carries no bit.
                    if (cnt_q < LOW_MAX_C) begin
                        pend_bit_d   = (cnt_q < ONE_MAX_C);
                        pend_valid_d = 1'b1;
                    end
                    state_d = StHigh;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= LOW_MAX_C) begin
                    err_d = 1'b1;
                end
            end
            StHigh: begin
                if (fall) begin
                    if (pend_valid_q) begin
                        shreg_d      = {shreg_q[6:0], pend_bit_q};
                        bit_cnt_d    = bit_cnt_q + 3'd1;
                        pend_valid_d = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shreg_q[6:0], pend_bit_q};
                            rx_valid_d = 1'b1;
                        end
                    end
                    state_d = StLow;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= IDLE_MAX_C) begin
                    // Pending bit here is the stop bit; it is dropped.
                    frame_done_d = 1'b1;
                    frame_err_d  = err_q | (bit_cnt_q != 3'd0) | ~pend_valid_q;
                    shreg_d      = 8'h00;
                    bit_cnt_d    = 3'd0;
                    pend_valid_d = 1'b0;
                    err_d        = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            s3_q         <= 1'b1;
            state_q      <= StIdle;
            cnt_q        <= '0;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            pend_bit_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            s1_q         <= din;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            pend_bit_q   <= pend_bit_d;
            pend_valid_q <= pend_valid_d;
            err_q        <= err_d;
            rx_data      <= rx_data_d;
            rx_valid     <= rx_valid_d;
            frame_done   <= frame_done_d;
            frame_err    <= frame_err_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: doc/n64_bit_rx.md
Name: n64_bit_rx

Overview:
- Receive-side counterpart to the codebase's timebase/divider logic. It measures pulse widths rather than generating them.
- Samples the N64 Joybus data line and decodes pulse-width-coded bits into bytes, using a clock-cycle timebase of US_CYCLES per microsecond.
- Detects the end of a frame from idle-line timeout and discards the trailing stop bit.
- Sits between the bidirectional pad (input path) and the controller-response parser.

Parameters:
- US_CYCLES, 12, clock cycles per microsecond (12 MHz iCEstick clock).
- ONE_MAX_US, 2, a low pulse strictly shorter than ONE_MAX_US*US_CYCLES cycles decodes as '1'; otherwise '0'.
- LOW_MAX_US, 5, a low pulse reaching LOW_MAX_US*US_CYCLES cycles is a line fault.
- IDLE_US, 5, high time reaching IDLE_US*US_CYCLES cycles ends the frame.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- din  input  1  raw Joybus line, asynchronous, idle high.
- rx_data  output  8  last completed byte, MSB received first.
- rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
- frame_done  output  1  one-cycle pulse at end of frame.
- frame_err  output  1  qualifies frame_done; asserted only in the frame_done cycle.
- busy  output  1  high from the first falling edge until frame_done.

Behaviour:
- Interface: one clock (clk_in); reset is asynchronous and active-high (rst).
- All state is cleared asynchronously on rst. Output reset values: rx_data=0x00, rx_valid=0, frame_done=0, frame_err=0, busy=0. Synchronizer flops reset to 1 (idle).
- Input path:
  - din passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Falling and rising edges are detected 3 cycles after the pad transition.
- Counter: a single duration counter, width $clog2(max(LOW_MAX_US,IDLE_US)*US_CYCLES+1). It saturates and never wraps.
- FSM states: IDLE, LOW, HIGH.
  - IDLE: waits for a falling edge. Falling edge -> LOW, counter=1, busy=1.
  - LOW: counter increments each cycle.
    - Rising edge -> classify the pulse: counter < ONE_MAX_US*US_CYCLES gives bit '1', else '0'. Store the result as the pending bit, set pend_valid, counter=1, go to HIGH.
    - Counter reaches LOW_MAX_US*US_CYCLES -> set the err flag, then wait for the rising edge without classifying. The next state is HIGH.
  - HIGH: counter increments each cycle.
    - Falling edge -> if pend_valid, commit the pending bit into the shift register (shift left, LSB in) and increment bit_cnt (3 bits). Go to LOW, counter=1.
    - Counter reaches IDLE_US*US_CYCLES -> frame end. The pending bit is the stop bit and is discarded, whatever its value. Pulse frame_done, clear busy, go to IDLE.
- Byte completion:
  - When a commit makes bit_cnt wrap 7->0, rx_data takes the full shifted byte and rx_valid pulses in the same cycle as the commit.
  - Latency: the byte appears at the falling edge that starts the bit after the 8th data bit, plus 3 sync cycles.
- frame_err is set with frame_done if any of these hold:
  - the err flag is set;
  - bit_cnt != 0 at frame end (partial byte; partial bits are discarded and produce no rx_valid);
  - no pending bit exists at frame end.
- At frame end the shift register, bit_cnt, pend_valid and err are cleared.
- Simultaneous events: edges are only sampled once per cycle after synchronization, so no simultaneous-edge case exists. A timeout and an edge in the same cycle resolve in favour of the edge.
- rst asserted mid-frame aborts immediately. No frame_done is produced for the aborted frame.

Test Plan:
- Byte 0x80 followed by a 1 µs-low stop bit and idle (bit '1' = 12 low/36 high cycles, bit '0' = 36 low/12 high) -> rx_valid pulses once with rx_data=0x80. frame_done pulses 60 cycles after the stop-bit rising edge (+3), frame_err=0.
- Two bytes 0x00 then 0xFF, then stop bit -> two rx_valid pulses, 0x00 then 0xFF, then one frame_done with frame_err=0.
- Low-width boundary: pulses of 23 and 24 low cycles -> decoded '1' and '0' respectively.
- Line held low 70 cycles mid-byte, then released and idle -> no rx_valid; frame_done with frame_err=1.
- 5 data bits plus stop bit, then idle -> no rx_valid; frame_done with frame_err=1.
- rst pulse after 4 bits of a frame, then a clean 0xA5 frame -> all outputs at 0 during reset; afterwards rx_data=0xA5 and frame_err=0.
